// File: rtl/sync_stream_axis_tx_pkg.sv
// Shared types and FIFO entry layout for the sync-to-AXI4-Stream transmit bridge.
// An entry is {sof, eol, pixel}, so its width and field positions follow DATA_W.
package sync_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam int FLAG_BITS = 2;

  function automatic int entry_w(input int data_w);
    return data_w + FLAG_BITS;
  endfunction

  function automatic int eol_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int sof_pos(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/sync_stream_axis_tx_if.sv
// AXI4-Stream video bus carrying framed pixels out of the transmit bridge.
interface sync_stream_axis_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] TDATA;
  logic              TSTRB;
  logic              TLAST;
  logic              TUSER;
  logic              TVALID;
  logic              TREADY;

  modport master (
    output TDATA, TSTRB, TLAST, TUSER, TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA, TSTRB, TLAST, TUSER, TVALID,
    output TREADY
  );

endinterface

// File: rtl/sync_stream_axis_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Storage is not reset, only pointers and occupancy are.
module stream_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_stream_axis_tx.sv
// Converts the sync-timed pixel stream into framed AXI4-Stream video (TUSER = SOF,
// TLAST = EOL) with a FIFO absorbing TREADY stalls; overflow drops the rest of the frame.
module sync_stream_axis_tx
  import sync_stream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  H_SYNC,
  input  logic                  V_SYNC,
  input  logic                  DATA_EN,
  input  logic [DATA_W-1:0]     pixel,
  input  logic [10:0]           width_in,
  input  logic [10:0]           height_in,
  sync_stream_axis_tx_if.master axis,
  output logic                  ovf,
  output logic                  frame_err
);

  localparam int EW      = entry_w(DATA_W);
  localparam int SOF_POS = sof_pos(DATA_W);
  localparam int EOL_POS = eol_pos(DATA_W);

  state_t      state;
  state_t      state_nx;
  logic        vs_d;
  logic        rise;
  logic        early;
  logic        size_zero;
  logic [10:0] w_m1;
  logic [10:0] h_m1;
  logic [10:0] col;
  logic [10:0] row;
  logic        last_col;
  logic        last_px;
  logic        sof;
  logic        ovf_q;
  logic        err_q;
  logic        err_pulse;
  logic        push_req;
  logic        enter_drop;
  logic        surplus;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic [EW-1:0] din;
  logic [EW-1:0] dout;
  logic        unused_hsync;

  // Line framing comes from the programmed width, not from H_SYNC.
  assign unused_hsync = H_SYNC;

  assign rise      = V_SYNC && !vs_d;
  assign early     = rise && ((state == ACTIVE) || (state == DROP));
  assign size_zero = (width_in == 11'd0) || (height_in == 11'd0);
  assign last_col  = (col == w_m1);
  assign last_px   = last_col && (row == h_m1);
  assign pop       = !fifo_empty && axis.TREADY;
  assign accept    = !fifo_full || pop;
  assign din       = {sof, last_col, pixel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A frame start overrides whatever the current frame was doing.
  always_comb begin
    state_nx = state;
    if (rise) begin
      state_nx = size_zero ? IDLE : ACTIVE;
    end else begin
      unique case (state)
        ACTIVE: begin
          if (DATA_EN) begin
            if (!accept) begin
              state_nx = DROP;
            end else if (last_px) begin
              state_nx = DONE;
            end
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    push_req   = 1'b0;
    enter_drop = 1'b0;
    surplus    = 1'b0;
    if (!rise) begin
      unique case (state)
        ACTIVE: begin
          push_req   = DATA_EN && accept;
          enter_drop = DATA_EN && !accept;
        end
        DONE:    surplus = DATA_EN;
        default: ;
      endcase
    end
  end

  // Frame bookkeeping: sizes, position counters, SOF arm and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= 1'b0;
      w_m1      <= '0;
      h_m1      <= '0;
      col       <= '0;
      row       <= '0;
      sof       <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      vs_d <= V_SYNC;
      if (rise) begin
        w_m1      <= width_in - 11'd1;
        h_m1      <= height_in - 11'd1;
        col       <= '0;
        row       <= '0;
        sof       <= 1'b1;
        ovf_q     <= 1'b0;
        err_q     <= early;
        err_pulse <= early;
      end else begin
        err_pulse <= 1'b0;
        if (push_req) begin
          sof <= 1'b0;
          if (last_col) begin
            col <= '0;
            row <= row + 11'd1;
          end else begin
            col <= col + 11'd1;
          end
        end
        if (enter_drop) begin
          ovf_q <= 1'b1;
        end
        // An early-frame error is only shown for one cycle before the new frame clears it.
        if (err_pulse) begin
          err_q <= 1'b0;
        end else if (surplus) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  stream_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Payload is masked while empty so the bus idles at zero regardless of stale storage.
  assign axis.TVALID = !fifo_empty;
  assign axis.TSTRB  = !fifo_empty;
  assign axis.TDATA  = fifo_empty ? '0 : dout[DATA_W-1:0];
  assign axis.TLAST  = !fifo_empty && dout[EOL_POS];
  assign axis.TUSER  = !fifo_empty && dout[SOF_POS];

  assign ovf       = ovf_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_sync_stream_axis_tx.sv
// Directed bench for sync_stream_axis_tx: framing, backpressure, overflow, frame errors, reset.
module tb_sync_stream_axis_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        H_SYNC = 1'b0;
  logic        V_SYNC = 1'b0;
  logic        DATA_EN = 1'b0;
  logic [7:0]  pixel = 8'h00;
  logic [10:0] width_in = 11'd0;
  logic [10:0] height_in = 11'd0;
  logic        ovf;
  logic        frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int stab_err = 0;

  logic [9:0] beats[$];
  logic       held = 1'b0;
  logic [9:0] held_val = '0;

  sync_stream_axis_tx_if #(.DATA_W(8)) axis ();

  sync_stream_axis_tx #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .H_SYNC    (H_SYNC),
    .V_SYNC    (V_SYNC),
    .DATA_EN   (DATA_EN),
    .pixel     (pixel),
    .width_in  (width_in),
    .height_in (height_in),
    .axis      (axis),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Beats are recorded half a cycle before the edge that completes the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && (!axis.TVALID || ({axis.TUSER, axis.TLAST, axis.TDATA} != held_val))) begin
        stab_err++;
      end
      if (axis.TVALID && axis.TREADY) begin
        beats.push_back({axis.TUSER, axis.TLAST, axis.TDATA});
      end
      held     = axis.TVALID && !axis.TREADY;
      held_val = {axis.TUSER, axis.TLAST, axis.TDATA};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] beat(input int i);
    if (i < beats.size()) return beats[i];
    return 10'h3FF;
  endfunction

  task automatic frame_start(input logic [10:0] w, input logic [10:0] h);
    width_in  = w;
    height_in = h;
    V_SYNC    = 1'b1;
    tick();
    V_SYNC    = 1'b0;
  endtask

  task automatic send(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      DATA_EN = 1'b1;
      pixel   = start + 8'(i);
      tick();
    end
    DATA_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    axis.TREADY = 1'b0;
    idle(2);
    chk("rst_tvalid", axis.TVALID, 0);
    chk("rst_tdata", axis.TDATA, 0);
    chk("rst_tlast", axis.TLAST, 0);
    chk("rst_tuser", axis.TUSER, 0);
    chk("rst_tstrb", axis.TSTRB, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_tvalid", axis.TVALID, 0);

    // Frame 4x2 at full rate
    axis.TREADY = 1'b1;
    frame_start(11'd4, 11'd2);
    DATA_EN = 1'b1;
    pixel   = 8'h10;
    tick();
    chk("lat_tvalid", axis.TVALID, 1);
    chk("lat_tdata", axis.TDATA, 8'h10);
    chk("lat_tuser", axis.TUSER, 1);
    chk("lat_tstrb", axis.TSTRB, 1);
    send(8'h11, 7);
    idle(3);
    chk("t1_count", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_beat", beat(i), {(i == 0), (i == 3 || i == 7), 8'(8'h10 + i)});
    end
    chk("t1_ovf", ovf, 0);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_drained", axis.TVALID, 0);
    beats.delete();

    // Same frame with TREADY toggling
    frame_start(11'd4, 11'd2);
    for (int c = 0; c < 40; c++) begin
      axis.TREADY = (c % 2 == 0);
      DATA_EN     = (c < 8);
      pixel       = 8'h10 + 8'(c);
      tick();
    end
    DATA_EN = 1'b0;
    axis.TREADY = 1'b1;
    idle(2);
    chk("t2_count", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_beat", beat(i), {(i == 0), (i == 3 || i == 7), 8'(8'h10 + i)});
    end
    chk("t2_stable", stab_err, 0);
    chk("t2_frame_err", frame_err, 0);
    beats.delete();

    // Overflow: 32-pixel line into a 16-entry FIFO with no drain
    axis.TREADY = 1'b0;
    frame_start(11'd32, 11'd1);
    send(8'h20, 16);
    chk("t3_ovf_full", ovf, 0);
    send(8'h30, 1);
    chk("t3_ovf_set", ovf, 1);
    send(8'h31, 15);
    chk("t3_ovf_held", ovf, 1);
    axis.TREADY = 1'b1;
    idle(24);
    chk("t3_count", beats.size(), 16);
    chk("t3_first", beat(0), {1'b1, 1'b0, 8'h20});
    chk("t3_last", beat(15), {1'b0, 1'b0, 8'h2F});
    chk("t3_stable", stab_err, 0);
    beats.delete();

    // Early V_SYNC: restart from DROP clears ovf and pulses frame_err
    axis.TREADY = 1'b0;
    frame_start(11'd4, 11'd2);
    chk("t4_ovf_clr", ovf, 0);
    chk("t4_err_drop", frame_err, 1);
    send(8'h40, 5);
    chk("t4_err_cleared", frame_err, 0);
    V_SYNC = 1'b1;
    tick();
    V_SYNC = 1'b0;
    chk("t4_err_pulse", frame_err, 1);
    send(8'h50, 1);
    chk("t4_err_after", frame_err, 0);
    axis.TREADY = 1'b1;
    idle(10);
    chk("t4_count", beats.size(), 6);
    chk("t4_b0", beat(0), {1'b1, 1'b0, 8'h40});
    chk("t4_b3", beat(3), {1'b0, 1'b1, 8'h43});
    chk("t4_b4", beat(4), {1'b0, 1'b0, 8'h44});
    chk("t4_b5", beat(5), {1'b1, 1'b0, 8'h50});
    beats.delete();

    // Surplus pixels after a complete 4x1 frame
    frame_start(11'd4, 11'd1);
    send(8'h60, 4);
    chk("t5_no_err", frame_err, 0);
    send(8'h64, 2);
    idle(4);
    chk("t5_count", beats.size(), 4);
    chk("t5_b0", beat(0), {1'b1, 1'b0, 8'h60});
    chk("t5_b3", beat(3), {1'b0, 1'b1, 8'h63});
    chk("t5_err_sticky", frame_err, 1);
    beats.delete();

    // Zero width: frame is ignored
    frame_start(11'd0, 11'd2);
    chk("t6_err_clr", frame_err, 0);
    send(8'h70, 4);
    idle(3);
    chk("t6_count", beats.size(), 0);
    chk("t6_tvalid", axis.TVALID, 0);

    // Reset in the middle of a frame
    axis.TREADY = 1'b0;
    frame_start(11'd4, 11'd2);
    send(8'h80, 3);
    chk("t7_pre_tvalid", axis.TVALID, 1);
    chk("t7_pre_tdata", axis.TDATA, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_tvalid", axis.TVALID, 0);
    chk("t7_rst_tdata", axis.TDATA, 0);
    chk("t7_rst_tuser", axis.TUSER, 0);
    tick();
    rst_n = 1'b1;
    tick();
    axis.TREADY = 1'b1;
    send(8'h90, 3);
    idle(2);
    chk("t7_resume_idle", axis.TVALID, 0);
    chk("t7_count", beats.size(), 0);
    chk("t7_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
